// File: rtl/io_responder_pkg.sv
// rtl/io_responder_pkg.sv - shared types and widths for the IN/OUT responder
package io_responder_pkg;

    localparam int SW_W   = 15;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IO_IDLE         = 2'd0,
        IO_WAIT_PRESS   = 2'd1,
        IO_ACK          = 2'd2,
        IO_WAIT_RELEASE = 2'd3
    } io_state_e;

    // Switch bank zero-extended to the register width for write-back
    function automatic logic [DATA_W-1:0] extend_sw(input logic [SW_W-1:0] sw);
        return {{(DATA_W - SW_W){1'b0}}, sw};
    endfunction

endpackage

// File: rtl/io_responder_if.sv
// rtl/io_responder_if.sv - core/board side signal bundle of the IN/OUT responder
interface io_responder_if;
    import io_responder_pkg::*;

    logic              input_flag;
    logic              output_flag;
    logic [DATA_W-1:0] out_data;
    logic              insert;
    logic [SW_W-1:0]   SW;
    logic              stall;
    logic              done;
    logic [DATA_W-1:0] user_input;
    logic [DATA_W-1:0] display;
    logic [1:0]        state_dbg;

    modport master (
        output input_flag, output_flag, out_data, insert, SW,
        input  stall, done, user_input, display, state_dbg
    );

    modport slave (
        input  input_flag, output_flag, out_data, insert, SW,
        output stall, done, user_input, display, state_dbg
    );
endinterface

// File: rtl/io_debounce.sv
// rtl/io_debounce.sv - pushbutton synchronizer, debouncer and press detector
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer, then flip the level only after a full run of disagreeing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync2;
                press <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/io_responder.sv
// rtl/io_responder.sv - IN/OUT handshake responder with switch capture and display latch
module io_responder
    import io_responder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit CONFIRM_OUT     = 1'b0
) (
    input logic          CLK,
    input logic          reset,
    io_responder_if.slave io
);
    io_state_e         state;
    logic              is_in;
    logic              level;
    logic              press;
    logic              done_q;
    logic [DATA_W-1:0] user_input_q;
    logic [DATA_W-1:0] display_q;

    io_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk  (CLK),
        .reset(reset),
        .raw  (io.insert),
        .level(level),
        .press(press)
    );

    // The PC is released only in ACK, so one press retires exactly one request
    assign io.stall      = (io.input_flag | (io.output_flag & CONFIRM_OUT)) & (state != IO_ACK);
    assign io.done       = done_q;
    assign io.user_input = user_input_q;
    assign io.display    = display_q;
    assign io.state_dbg  = state;

    // Request FSM; IN wins when both flags are high, and a withdrawn request retires silently
    always_ff @(posedge CLK) begin
        if (reset) begin
            state        <= IO_IDLE;
            is_in        <= 1'b0;
            done_q       <= 1'b0;
            user_input_q <= '0;
            display_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IO_IDLE: begin
                    if (io.input_flag) begin
                        is_in <= 1'b1;
                        state <= IO_WAIT_PRESS;
                    end else if (io.output_flag) begin
                        is_in     <= 1'b0;
                        display_q <= io.out_data;
                        if (CONFIRM_OUT) begin
                            state <= IO_WAIT_PRESS;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                IO_WAIT_PRESS: begin
                    if (!io.input_flag && !io.output_flag) begin
                        state <= IO_IDLE;
                    end else if (press) begin
                        if (is_in) begin
                            user_input_q <= extend_sw(io.SW);
                        end
                        done_q <= 1'b1;
                        state  <= IO_ACK;
                    end
                end
                IO_ACK: begin
                    state <= level ? IO_WAIT_RELEASE : IO_IDLE;
                end
                IO_WAIT_RELEASE: begin
                    if (!level) begin
                        state <= IO_IDLE;
                    end
                end
                default: state <= IO_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - directed bench for io_responder with a window-based reference model
module tb_io_responder;
    import io_responder_pkg::*;

    localparam int DB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn = 1'b0;
    logic [14:0] sw = '0;

    always #5 clk = ~clk;

    io_responder_if if0 ();
    io_responder_if if1 ();

    assign if0.insert = btn;
    assign if1.insert = btn;
    assign if0.SW     = sw;
    assign if1.SW     = sw;

    io_responder #(.DEBOUNCE_CYCLES(DB), .CONFIRM_OUT(1'b0)) dut0 (
        .CLK  (clk),
        .reset(reset),
        .io   (if0.slave)
    );

    io_responder #(.DEBOUNCE_CYCLES(DB), .CONFIRM_OUT(1'b1)) dut1 (
        .CLK  (clk),
        .reset(reset),
        .io   (if1.slave)
    );

    int tests = 0;
    int fails = 0;
    bit mon_en = 0;
    int ndone [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the debounced level flips once the last DB synchronized samples all disagree
    bit          hist [DB+1];
    bit          m_level;
    bit          m_press;
    int          m_state [2];
    bit          m_isin [2];
    bit          m_done [2];
    logic [31:0] m_ui [2];
    logic [31:0] m_disp [2];

    task automatic fsm_step(input int k, input bit conf, input logic inf, input logic outf,
                            input logic [31:0] od);
        m_done[k] = 1'b0;
        case (m_state[k])
            0: begin
                if (inf) begin
                    m_state[k] = 1;
                    m_isin[k]  = 1'b1;
                end else if (outf) begin
                    m_disp[k] = od;
                    m_isin[k] = 1'b0;
                    if (conf) m_state[k] = 1;
                    else      m_done[k]  = 1'b1;
                end
            end
            1: begin
                if (!inf && !outf) begin
                    m_state[k] = 0;
                end else if (m_press) begin
                    if (m_isin[k]) m_ui[k] = {17'b0, sw};
                    m_state[k] = 2;
                    m_done[k]  = 1'b1;
                end
            end
            2: m_state[k] = m_level ? 3 : 0;
            default: begin
                if (!m_level) m_state[k] = 0;
            end
        endcase
    endtask

    always @(posedge clk) begin
        bit all_diff;
        if (reset) begin
            for (int i = 0; i <= DB; i++) hist[i] = 1'b0;
            m_level = 1'b0;
            m_press = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_state[k] = 0;
                m_isin[k]  = 1'b0;
                m_done[k]  = 1'b0;
                m_ui[k]    = '0;
                m_disp[k]  = '0;
            end
        end else begin
            fsm_step(0, 1'b0, if0.input_flag, if0.output_flag, if0.out_data);
            fsm_step(1, 1'b1, if1.input_flag, if1.output_flag, if1.out_data);
            all_diff = 1'b1;
            for (int i = 0; i < DB; i++) if (hist[i] == m_level) all_diff = 1'b0;
            m_press = 1'b0;
            if (all_diff) begin
                m_level = !m_level;
                m_press = m_level;
            end
            for (int i = 0; i < DB; i++) hist[i] = hist[i+1];
            hist[DB] = btn;
        end
    end

    task automatic cmp(input int k, input bit conf, input logic inf, input logic outf,
                       input logic stall, input logic done, input logic [31:0] ui,
                       input logic [31:0] disp, input logic [1:0] st);
        bit es;
        es = (inf | (outf & conf)) && (m_state[k] != 2);
        chk($sformatf("dut%0d_stall", k), {31'b0, stall}, {31'b0, es});
        chk($sformatf("dut%0d_done", k), {31'b0, done}, {31'b0, m_done[k]});
        chk($sformatf("dut%0d_user_input", k), ui, m_ui[k]);
        chk($sformatf("dut%0d_display", k), disp, m_disp[k]);
        chk($sformatf("dut%0d_state", k), {30'b0, st}, m_state[k]);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cmp(0, 1'b0, if0.input_flag, if0.output_flag, if0.stall, if0.done,
                if0.user_input, if0.display, if0.state_dbg);
            cmp(1, 1'b1, if1.input_flag, if1.output_flag, if1.stall, if1.done,
                if1.user_input, if1.display, if1.state_dbg);
            if (if0.done === 1'b1) ndone[0]++;
            if (if1.done === 1'b1) ndone[1]++;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v);
        if0.input_flag = v;
        if1.input_flag = v;
    endtask

    // Counts edges until done is seen (sampled at the following negedge); -1 when the budget runs out
    task automatic wait_done(input int k, input int budget, output int n);
        logic d;
        int   cnt;
        cnt = 0;
        n   = -1;
        while (cnt < budget) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            d = (k == 0) ? if0.done : if1.done;
            if (d === 1'b1) begin
                n = cnt;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int d0;
        int d1;
        if0.input_flag = 1'b0; if0.output_flag = 1'b0; if0.out_data = '0;
        if1.input_flag = 1'b0; if1.output_flag = 1'b0; if1.out_data = '0;
        ndone[0] = 0;
        ndone[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_state", {30'b0, if0.state_dbg}, 32'd0);
        chk("reset_user_input", if0.user_input, 32'h0);
        chk("reset_display", if1.display, 32'h0);
        chk("reset_done", {31'b0, if0.done}, 32'd0);
        chk("reset_stall", {31'b0, if0.stall}, 32'd0);
        sync();

        // clean press held 40 cycles
        sw = 15'h1234;
        set_in(1'b1);
        repeat (3) sync();
        d0 = ndone[0];
        btn = 1'b1;
        wait_done(0, 40, n);
        chk("t1_press_to_done_edges", n, 32'd19);
        chk("t1_ack_stall", {31'b0, if0.stall}, 32'd0);
        chk("t1_user_input", if0.user_input, 32'h00001234);
        chk("t1_user_input_dut1", if1.user_input, 32'h00001234);
        sync();
        set_in(1'b0);
        repeat (21) sync();
        btn = 1'b0;
        repeat (25) sync();
        chk("t1_done_count", ndone[0] - d0, 32'd1);

        // bouncing button, then a stable press
        sw = 15'h7abc;
        set_in(1'b1);
        repeat (3) sync();
        d0 = ndone[0];
        for (int b = 0; b < 3; b++) begin
            btn = 1'b1;
            repeat (5) sync();
            btn = 1'b0;
            repeat (5) sync();
        end
        repeat (4) sync();
        chk("t2_no_bounce_done", ndone[0] - d0, 32'd0);
        btn = 1'b1;
        wait_done(0, 40, n);
        chk("t2_press_to_done_edges", n, 32'd19);
        chk("t2_user_input", if0.user_input, 32'h00007abc);
        sync();
        set_in(1'b0);
        repeat (10) sync();
        btn = 1'b0;
        repeat (25) sync();
        chk("t2_done_count", ndone[0] - d0, 32'd1);

        // back-to-back INs with the button held across both
        sw = 15'h0321;
        set_in(1'b1);
        repeat (3) sync();
        d0 = ndone[0];
        btn = 1'b1;
        wait_done(0, 40, n);
        chk("t3_first_user_input", if0.user_input, 32'h00000321);
        sync();
        sw = 15'h0555;
        @(negedge clk);
        chk("t3_wait_release_state", {30'b0, if0.state_dbg}, 32'd3);
        chk("t3_wait_release_stall", {31'b0, if0.stall}, 32'd1);
        sync();
        repeat (30) sync();
        btn = 1'b0;
        repeat (25) sync();
        chk("t3_held_no_second_done", ndone[0] - d0, 32'd1);
        @(negedge clk);
        chk("t3_rearmed_state", {30'b0, if0.state_dbg}, 32'd1);
        sync();
        btn = 1'b1;
        wait_done(0, 40, n);
        chk("t3_second_press_edges", n, 32'd19);
        chk("t3_second_user_input", if0.user_input, 32'h00000555);
        sync();
        set_in(1'b0);
        btn = 1'b0;
        repeat (25) sync();
        chk("t3_done_count", ndone[0] - d0, 32'd2);

        // OUT without confirmation
        d0 = ndone[0];
        if0.out_data    = 32'hdeadbeef;
        if0.output_flag = 1'b1;
        @(negedge clk);
        chk("t4_no_stall", {31'b0, if0.stall}, 32'd0);
        sync();
        if0.output_flag = 1'b0;
        @(negedge clk);
        chk("t4_display", if0.display, 32'hdeadbeef);
        chk("t4_done", {31'b0, if0.done}, 32'd1);
        sync();
        @(negedge clk);
        chk("t4_done_drop", {31'b0, if0.done}, 32'd0);
        chk("t4_done_count", ndone[0] - d0, 32'd1);
        sync();

        // OUT with confirmation
        d1 = ndone[1];
        if1.out_data    = 32'hcafef00d;
        if1.output_flag = 1'b1;
        sync();
        @(negedge clk);
        chk("t5_display_on_entry", if1.display, 32'hcafef00d);
        chk("t5_stall", {31'b0, if1.stall}, 32'd1);
        chk("t5_state", {30'b0, if1.state_dbg}, 32'd1);
        sync();
        repeat (3) sync();
        btn = 1'b1;
        wait_done(1, 40, n);
        chk("t5_press_to_done_edges", n, 32'd19);
        chk("t5_user_input_kept", if1.user_input, 32'h00000555);
        sync();
        if1.output_flag = 1'b0;
        btn = 1'b0;
        repeat (25) sync();
        chk("t5_done_count", ndone[1] - d1, 32'd1);

        // reset during WAIT_PRESS with the button held through it
        sw = 15'h1111;
        set_in(1'b1);
        repeat (3) sync();
        btn = 1'b1;
        repeat (5) sync();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_reset_state", {30'b0, if0.state_dbg}, 32'd0);
        chk("t6_reset_user_input", if0.user_input, 32'h0);
        chk("t6_reset_display0", if0.display, 32'h0);
        chk("t6_reset_display1", if1.display, 32'h0);
        chk("t6_reset_done", {31'b0, if0.done}, 32'd0);
        sync();
        reset = 1'b0;
        wait_done(0, 40, n);
        chk("t6_held_button_new_press", n, 32'd19);
        chk("t6_user_input", if0.user_input, 32'h00001111);
        sync();
        set_in(1'b0);
        btn = 1'b0;
        repeat (25) sync();

        // request withdrawn while waiting
        set_in(1'b1);
        repeat (5) sync();
        @(negedge clk);
        chk("t7_waiting_state", {30'b0, if0.state_dbg}, 32'd1);
        d0 = ndone[0];
        sync();
        set_in(1'b0);
        sync();
        @(negedge clk);
        chk("t7_withdrawn_state", {30'b0, if0.state_dbg}, 32'd0);
        repeat (10) sync();
        chk("t7_no_done", ndone[0] - d0, 32'd0);
        chk("t7_user_input_kept", if0.user_input, 32'h00001111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
